// File: rtl/rgb_led_sched_pkg.sv
// Shared definitions for the RGB LED scheduler.
// Contents: level width, channel index width, default colour width,
// scheduler state encoding and the round-robin channel picker.
package rgb_led_sched_pkg;

    localparam int LVL_W  = 5;   // level index width into the colour lookup
    localparam int CH_W   = 3;   // channel index width (up to 8 channels)
    localparam int CW_DEF = 7;   // default colour/duty width

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } sched_state_t;

    // First enabled channel at or after 'start', wrapping at 'num'.
    // Returns 'start' when nothing is enabled (caller only uses the
    // result when at least one enable bit is set).
    function automatic logic [CH_W-1:0] rr_pick(input logic [7:0] en,
                                                input logic [CH_W-1:0] start,
                                                input int num);
        logic [CH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(start) + i) % num;
            if (!found && (i < num) && en[idx[2:0]]) begin
                pick  = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rgb_led_sched_if.sv
// Bus between the scheduler and the shared colour lookup.
// master: scheduler (drives lut_res_o, receives lut_r_i/g_i/b_i)
// slave : lookup    (registers colour values one clk after lut_res_o)
interface rgb_led_sched_if #(
    parameter int CW = 7
);
    import rgb_led_sched_pkg::*;

    logic [LVL_W-1:0] lut_res_o;
    logic [CW-1:0]    lut_r_i;
    logic [CW-1:0]    lut_g_i;
    logic [CW-1:0]    lut_b_i;

    modport master (output lut_res_o, input lut_r_i, lut_g_i, lut_b_i);
    modport slave  (input lut_res_o, output lut_r_i, lut_g_i, lut_b_i);

endinterface

// File: rtl/rgb_led_sched_pwm_ch.sv
// One RGB channel: pending duties (written by the scheduler), active
// duties (copied from pending only at PWM period boundaries), and the
// registered PWM compare.
// Ports: clk, reset_n (async, active low), en (channel enable),
//        cap (write pending duties), load (period-boundary strobe),
//        pwm_cnt (shared counter), r_in/g_in/b_in (lookup values),
//        led_r/led_g/led_b (active-high PWM outputs).
module rgb_pwm_ch #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          cap,
    input  logic          load,
    input  logic [CW-1:0] pwm_cnt,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    output logic          led_r,
    output logic          led_g,
    output logic          led_b
);
    logic [CW-1:0] pend_r_reg, pend_g_reg, pend_b_reg;
    logic [CW-1:0] act_r_reg, act_g_reg, act_b_reg;
    logic          led_r_reg, led_g_reg, led_b_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r_reg <= '0;
            pend_g_reg <= '0;
            pend_b_reg <= '0;
            act_r_reg  <= '0;
            act_g_reg  <= '0;
            act_b_reg  <= '0;
            led_r_reg  <= 1'b0;
            led_g_reg  <= 1'b0;
            led_b_reg  <= 1'b0;
        end else begin
            if (cap) begin
                pend_r_reg <= r_in;
                pend_g_reg <= g_in;
                pend_b_reg <= b_in;
            end
            // A capture on the same edge lands in pend and is picked up
            // at the next boundary, so a period never mixes duties.
            if (load) begin
                act_r_reg <= pend_r_reg;
                act_g_reg <= pend_g_reg;
                act_b_reg <= pend_b_reg;
            end
            // Disabling forces the pin low but keeps the duty registers.
            led_r_reg <= en && (pwm_cnt < act_r_reg);
            led_g_reg <= en && (pwm_cnt < act_g_reg);
            led_b_reg <= en && (pwm_cnt < act_b_reg);
        end
    end

    assign led_r = led_r_reg;
    assign led_g = led_g_reg;
    assign led_b = led_b_reg;

endmodule

// File: rtl/rgb_led_sched.sv
// Round-robin sharing of one registered colour lookup between NUM_LED
// RGB LED channels, with glitch-free per-channel PWM.
// Ports: clk, reset_n (async, active low), lvl_i (5 bits per channel),
//        en_i (per-channel enable), lut (lookup bus, master side),
//        led_r_o/led_g_o/led_b_o (PWM pins), upd_o/upd_ch_o (pulse and
//        channel index whenever a channel's pending duty is written).
module rgb_led_sched
    import rgb_led_sched_pkg::*;
#(
    parameter int NUM_LED = 2,
    parameter int CW      = CW_DEF,
    parameter int PWM_DIV = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [LVL_W*NUM_LED-1:0] lvl_i,
    input  logic [NUM_LED-1:0]       en_i,
    rgb_led_sched_if.master          lut,
    output logic [NUM_LED-1:0]       led_r_o,
    output logic [NUM_LED-1:0]       led_g_o,
    output logic [NUM_LED-1:0]       led_b_o,
    output logic                     upd_o,
    output logic [CH_W-1:0]          upd_ch_o
);
    localparam int PS_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    sched_state_t     state_reg, state_next;
    logic [CH_W-1:0]  ch_reg, ch_next;
    logic [LVL_W-1:0] lut_res_reg;
    logic             upd_reg;
    logic [CH_W-1:0]  upd_ch_reg;
    logic [PS_W-1:0]  presc_reg;
    logic [CW-1:0]    pwm_cnt_reg;
    logic             tick;
    logic             load;
    logic [7:0]       en_pad;
    logic [LVL_W-1:0] lvl_arr [8];

    assign en_pad = 8'(en_i);

    // Level table padded to 8 entries so the 3-bit channel index always
    // addresses a defined entry.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lvl
        if (gi < NUM_LED) begin : g_used
            assign lvl_arr[gi] = lvl_i[LVL_W*gi +: LVL_W];
        end else begin : g_pad
            assign lvl_arr[gi] = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|en_i) begin
                    ch_next    = rr_pick(en_pad, ch_reg, NUM_LED);
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_next = ST_WAIT;
            ST_WAIT:    state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                ch_next    = (ch_reg == CH_W'(NUM_LED - 1)) ? '0 : ch_reg + 1'b1;
                state_next = ST_IDLE;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            ch_reg      <= '0;
            lut_res_reg <= '0;
            upd_reg     <= 1'b0;
            upd_ch_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            if (state_reg == ST_ISSUE) begin
                lut_res_reg <= lvl_arr[ch_reg];
            end
            upd_reg <= (state_reg == ST_CAPTURE);
            if (state_reg == ST_CAPTURE) begin
                upd_ch_reg <= ch_reg;
            end
        end
    end

    // Prescaler and shared PWM counter; load fires on the last step of
    // every period.
    assign tick = (presc_reg == PS_W'(PWM_DIV - 1));
    assign load = tick && (&pwm_cnt_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_ch
        rgb_pwm_ch #(.CW(CW)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en_i[gi]),
            .cap     ((state_reg == ST_CAPTURE) && (ch_reg == CH_W'(gi))),
            .load    (load),
            .pwm_cnt (pwm_cnt_reg),
            .r_in    (lut.lut_r_i),
            .g_in    (lut.lut_g_i),
            .b_in    (lut.lut_b_i),
            .led_r   (led_r_o[gi]),
            .led_g   (led_g_o[gi]),
            .led_b   (led_b_o[gi])
        );
    end

    assign lut.lut_res_o = lut_res_reg;
    assign upd_o         = upd_reg;
    assign upd_ch_o      = upd_ch_reg;

endmodule
